// File: rtl/vx_tex_sat_arb.sv
// Round-robin arbiter that feeds one shared saturation stage.
// Signed IN_W inputs are clamped to unsigned OUT_W, and overflow/underflow events are counted.
module vx_tex_sat_arb #(
  parameter int NUM_REQS = 4,
  parameter int IN_W     = 24,
  parameter int OUT_W    = 8,
  parameter int TAG_W    = 4,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*IN_W-1:0]  req_data,
  input  logic [NUM_REQS*TAG_W-1:0] req_tag,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [IDX_W-1:0]          out_idx,
  input  logic                      out_ready,
  input  logic                      clr_cnt,
  output logic [15:0]               ovf_cnt,
  output logic [15:0]               unf_cnt
);

  if ((OUT_W + 1) >= IN_W) begin : g_bad_widths
    $error("vx_tex_sat_arb: OUT_W+1 must be smaller than IN_W");
  end
  if ((NUM_REQS < 2) || (NUM_REQS > 8)) begin : g_bad_reqs
    $error("vx_tex_sat_arb: NUM_REQS must be within 2..8");
  end

  logic [IN_W-1:0]     data_arr [NUM_REQS];
  logic [TAG_W-1:0]    tag_arr  [NUM_REQS];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*IN_W +: IN_W];
    assign tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
  end

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_next;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [NUM_REQS-1:0] grant;
  logic                found;
  int                  cand;
  logic                free;
  logic                accept;

  // Scan starts at the pointer and wraps, so the first valid hit is the grant.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    cand_idx = '0;
    cand     = 0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand     = (int'(ptr) + k) % NUM_REQS;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  assign free      = ~out_valid | out_ready;
  assign req_ready = (reset || !free) ? '0 : grant;
  assign accept    = |req_ready;
  assign ptr_next  = (gnt_idx == IDX_W'(NUM_REQS - 1)) ? '0 : gnt_idx + IDX_W'(1);

  logic [IN_W-1:0]  sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic             is_unf;
  logic             is_ovf;
  logic [OUT_W-1:0] sat_data;

  assign sel_data = data_arr[gnt_idx];
  assign sel_tag  = tag_arr[gnt_idx];
  assign is_unf   = sel_data[IN_W-1];
  assign is_ovf   = ~sel_data[IN_W-1] & (|sel_data[IN_W-2:OUT_W]);

  always_comb begin
    sat_data = sel_data[OUT_W-1:0];
    if (is_unf) begin
      sat_data = '0;
    end else if (is_ovf) begin
      sat_data = '1;
    end
  end

  // Payload is only loaded on accept; a free cycle without accept just drops out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (free) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sat_data;
        out_tag  <= sel_tag;
        out_idx  <= gnt_idx;
        ptr      <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (accept) begin
      if (is_ovf && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
      if (is_unf && (unf_cnt != 16'hFFFF)) begin
        unf_cnt <= unf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/vx_tex_sat_arb.md
VX_TEX_SAT_ARB -- requirements
Module: VX_tex_sat_arb

Interface
REQ-001: Parameter NUM_REQS, default 4, is the number of requesters sharing the saturation stage (legal range 2..8).
REQ-002: Parameter IN_W, default 24, is the signed fixed-point input width.
REQ-003: Parameter OUT_W, default 8, is the unsigned saturated output width; (OUT_W+1) < IN_W SHALL be statically asserted.
REQ-004: Parameter TAG_W, default 4, is the per-request tag width.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: reset  input  1  synchronous, active-high reset.
REQ-007: req_valid  input  NUM_REQS  per-requester request valid.
REQ-008: req_data  input  NUM_REQS*IN_W  per-requester signed value, requester i at bits [i*IN_W +: IN_W].
REQ-009: req_tag  input  NUM_REQS*TAG_W  per-requester tag, same packing.
REQ-010: req_ready  output  NUM_REQS  per-requester accept; handshake completes when req_valid[i] & req_ready[i].
REQ-011: out_valid  output  1  result valid.
REQ-012: out_data  output  OUT_W  saturated result.
REQ-013: out_tag  output  TAG_W  tag of the accepted request.
REQ-014: out_idx  output  $clog2(NUM_REQS)  index of the originating requester.
REQ-015: out_ready  input  1  downstream accept.
REQ-016: clr_cnt  input  1  synchronous clear of the event counters.
REQ-017: ovf_cnt  output  16  overflow event count.
REQ-018: unf_cnt  output  16  underflow event count.

Function
REQ-019: Arbitration SHALL be round-robin: the priority pointer names the highest-priority requester; the grant goes to the first valid requester at or after the pointer, wrapping modulo NUM_REQS.
REQ-020: Output register is free when ~out_valid | out_ready; req_ready[i] SHALL equal grant[i] & free, and at most one req_ready bit SHALL be high per cycle.
REQ-021: When no requester is valid or the register is not free, req_ready SHALL be all-zero and the pointer SHALL hold.
REQ-022: On an accepted request from requester g, the pointer SHALL become (g+1) mod NUM_REQS on the next edge.
REQ-023: Latency SHALL be exactly 1 cycle: a request accepted at edge t drives out_valid=1 with its result from edge t onward.
REQ-024: Saturation: input sign bit set -> 0; sign clear and any bit in [IN_W-2:OUT_W] set -> all ones; otherwise -> bits [OUT_W-1:0].
REQ-025: Output stall: while out_valid=1 and out_ready=0, out_valid, out_data, out_tag and out_idx SHALL hold unchanged.
REQ-026: If free and no request is accepted, out_valid SHALL go to 0 at the next edge.
REQ-027: Back-to-back: with out_ready=1 held high, one request SHALL be accepted per cycle.
REQ-028: An accepted overflow case SHALL increment ovf_cnt by 1; an accepted underflow case SHALL increment unf_cnt by 1.
REQ-029: Both counters SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-030: clr_cnt SHALL zero both counters at the next edge and takes priority over a same-cycle increment.
REQ-031: Inputs to non-granted requesters SHALL NOT affect outputs or counters.

Reset
REQ-032: On reset, out_valid=0, out_data=0, out_tag=0, out_idx=0, pointer=0, ovf_cnt=0 and unf_cnt=0, all at the next edge.
REQ-033: While reset is high, req_ready SHALL be all-zero.
REQ-034: A request pending or held in the output register when reset asserts SHALL be discarded, with no counter update.

Verification
REQ-035: Saturation (defaults): req 0 sends 0x000080 -> 0x80; 0x000100 -> 0xFF with ovf_cnt=1; 0xFFFF00 -> 0x00 with unf_cnt=1; 0x0000FF -> 0xFF with no counter change.
REQ-036: Fairness: all 4 requesters held valid, out_ready=1 -> out_idx sequence 0,1,2,3,0,1 on consecutive cycles, each tag matching its source.
REQ-037: Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, req_ready=0; after out_ready=1, the next grant follows the rotated pointer.
REQ-038: Sparse requests: pointer=2, only requesters 0 and 3 valid -> grant 3, then grant 0.
REQ-039: Counters: 65537 overflow inputs -> ovf_cnt=0xFFFF; clr_cnt asserted with a same-cycle overflow -> ovf_cnt=0.
REQ-040: Reset mid-stream: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, counters 0, pointer 0, and the first post-reset grant goes to the lowest valid index.
